// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the decode stage, the execute unit and the
// register file write port.
interface alu_exec_unit_if #(
    parameter int WORD_LENGTH = 8,
    parameter int REG_ADDR_W  = 2
);
    logic                   start;
    logic [2:0]             op;
    logic [REG_ADDR_W-1:0]  dest_reg;
    logic [WORD_LENGTH-1:0] operand_a;
    logic [WORD_LENGTH-1:0] operand_b;
    logic                   busy;
    logic                   done;
    logic [WORD_LENGTH-1:0] write_data;
    logic [REG_ADDR_W-1:0]  write_reg;
    logic                   write_reg_en;
    logic [2:0]             CZN;

    // Issuing side: drives requests and observes results
    modport master (
        output start, op, dest_reg, operand_a, operand_b,
        input  busy, done, write_data, write_reg, write_reg_en, CZN
    );

    // Execute unit side
    modport slave (
        input  start, op, dest_reg, operand_a, operand_b,
        output busy, done, write_data, write_reg, write_reg_en, CZN
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage feeding the register file write port. Logic/arithmetic ops
// complete in one cycle; MUL is an iterative shift-add unsigned multiply
// that runs for WORD_LENGTH cycles while busy is high.
module alu_exec_unit #(
    parameter int WORD_LENGTH = 8,
    parameter int REG_ADDR_W  = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_exec_unit_if.slave bus
);
    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         iter_cnt;
    logic [2*WORD_LENGTH-1:0] acc;
    logic [2*WORD_LENGTH-1:0] mcand;
    logic [WORD_LENGTH-1:0]   mplier;
    logic [REG_ADDR_W-1:0]    dest_q;

    logic [WORD_LENGTH-1:0]   alu_res;
    logic                     alu_c;
    logic [WORD_LENGTH:0]     wide;
    logic [2*WORD_LENGTH-1:0] next_acc;

    // Single-cycle result and carry/borrow computed straight from the issue inputs
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (bus.op)
            OP_ADD: begin
                wide    = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
                alu_res = wide[WORD_LENGTH-1:0];
                alu_c   = wide[WORD_LENGTH];
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is set exactly when a < b
                wide    = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
                alu_res = wide[WORD_LENGTH-1:0];
                alu_c   = wide[WORD_LENGTH];
            end
            OP_AND: alu_res = bus.operand_a & bus.operand_b;
            OP_OR:  alu_res = bus.operand_a | bus.operand_b;
            OP_XOR: alu_res = bus.operand_a ^ bus.operand_b;
            OP_SHL: begin
                alu_res = {bus.operand_a[WORD_LENGTH-2:0], 1'b0};
                alu_c   = bus.operand_a[WORD_LENGTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.operand_a[WORD_LENGTH-1:1]};
                alu_c   = bus.operand_a[0];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        next_acc = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM, multiply datapath and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            iter_cnt         <= '0;
            acc              <= '0;
            mcand            <= '0;
            mplier           <= '0;
            dest_q           <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.write_reg_en <= 1'b0;
            bus.write_data   <= '0;
            bus.write_reg    <= '0;
            bus.CZN          <= 3'b000;
        end else begin
            bus.done         <= 1'b0;
            bus.write_reg_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state    <= MUL;
                            bus.busy <= 1'b1;
                            iter_cnt <= '0;
                            acc      <= '0;
                            mcand    <= {{WORD_LENGTH{1'b0}}, bus.operand_a};
                            mplier   <= bus.operand_b;
                            dest_q   <= bus.dest_reg;
                        end else begin
                            bus.write_data   <= alu_res;
                            bus.write_reg    <= bus.dest_reg;
                            bus.CZN          <= {alu_res[WORD_LENGTH-1], (alu_res == '0), alu_c};
                            bus.done         <= 1'b1;
                            bus.write_reg_en <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc      <= next_acc;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == CNT_W'(WORD_LENGTH - 1)) begin
                        state            <= IDLE;
                        bus.busy         <= 1'b0;
                        bus.write_data   <= next_acc[WORD_LENGTH-1:0];
                        bus.write_reg    <= dest_q;
                        bus.CZN          <= {next_acc[WORD_LENGTH-1],
                                             (next_acc[WORD_LENGTH-1:0] == '0),
                                             (next_acc[2*WORD_LENGTH-1:WORD_LENGTH] != '0)};
                        bus.done         <= 1'b1;
                        bus.write_reg_en <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly upstream of register_file's write port.
- Consumes the two operands read from the register file and a decoded opcode.
- Produces `write_data`, `write_reg` and `write_reg_en` for the register file, plus a registered CZN flag vector.
- Single-cycle logic/arithmetic ops; multi-cycle 8-iteration shift-add unsigned multiply with a start/busy/done handshake.

Parameters:
- WORD_LENGTH, 8, operand/result width; the multiply takes WORD_LENGTH iterations.
- REG_ADDR_W, 2, destination register index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  issue request; sampled only when busy=0.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- dest_reg  input  REG_ADDR_W  destination register index.
- operand_a  input  WORD_LENGTH  first operand (register file read_data1).
- operand_b  input  WORD_LENGTH  second operand (register file read_data2).
- busy  output  1  high while a MUL is iterating.
- done  output  1  one-cycle pulse when the result is valid.
- write_data  output  WORD_LENGTH  result to register file.
- write_reg  output  REG_ADDR_W  destination index to register file.
- write_reg_en  output  1  one-cycle write strobe; identical timing to done.
- CZN  output  3  bit0 = C, bit1 = Z, bit2 = N; holds its value between completions.

Behaviour:
- Reset: synchronous active-high. On a clk edge with rst=1:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Any in-flight MUL is aborted with no write strobe.
  - rst has priority over start.
- FSM states:
  - IDLE: busy=0.
  - MUL: busy=1, 3-bit iteration counter.
  - No other states.
- Issue: start=1 in IDLE at edge T0 latches op, dest_reg, operand_a and operand_b.
  - Operand inputs may change after T0 without effect.
- Single-cycle ops (op≠111): result, write_reg and CZN are registered at T0.
  - done=1 and write_reg_en=1 for exactly the cycle following T0.
  - The FSM stays in IDLE, so back-to-back starts on consecutive cycles are legal.
  - Each such start yields its own one-cycle strobe.
- MUL:
  - At T0 the FSM enters MUL, busy=1, counter=0, and a 2×WORD_LENGTH accumulator is cleared.
  - Edges T1..T8 each perform one shift-add step, LSB of the multiplier first.
  - At T8 (counter=7) the FSM returns to IDLE.
  - After T8: busy=0, and done=1 / write_reg_en=1 for one cycle.
  - write_data = product[7:0].
- start while busy: ignored, not queued. Operands are not re-latched.
- done and write_reg_en are never asserted while busy=1.
- Result and flag rules (all widths WORD_LENGTH, unsigned):
  - ADD: sum modulo 2^8; C = carry-out.
  - SUB: operand_a − operand_b modulo 2^8; C = borrow (operand_a < operand_b).
  - AND / OR / XOR: C=0.
  - SHL: operand_a<<1, zero fill; C = operand_a[7].
  - SHR: logical operand_a>>1; C = operand_a[0].
  - MUL: C=1 iff product[15:8]≠0.
  - All ops: Z = (write_data == 0); N = write_data[7].
- Between completions:
  - write_data and write_reg hold their last values.
  - CZN holds.
  - write_reg_en=0 and done=0.
- Reset mid-MUL: returns to IDLE the next edge; no done pulse; CZN cleared to 0.

Test Plan:
- ADD, operand_a=200, operand_b=100, dest_reg=2 → next cycle done=1, write_reg_en=1, write_data=44, write_reg=2, CZN=3'b001; both strobes low the following cycle.
- SUB 5−5 → write_data=0, CZN=3'b010. Then SUB 3−5 on the very next cycle → write_data=254, CZN=3'b101, with two consecutive one-cycle strobes.
- MUL 15×17, dest_reg=1 → busy=1 for 8 cycles, then done=1 with write_data=255, CZN=3'b100. Then MUL 16×16 → write_data=0, CZN=3'b011.
- MUL 3×4 with start re-asserted (op=ADD) on cycles 2–5 of busy → those starts are ignored; a single done with write_data=12; no ADD result appears.
- Start MUL 200×200, assert rst at cycle 4 of busy → busy=0, write_reg_en never pulses, CZN=0, write_data=0. A following SHL 0x81 → write_data=0x02, CZN=3'b001.
- SHR 0x01 → write_data=0, CZN=3'b011. XOR 0xF0^0x0F → write_data=0xFF, CZN=3'b100.
